// File: rtl/vedic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vedic_pkg
// Purpose  : Shared constants for the pipelined Vedic multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package vedic_pkg;

    localparam int DEFAULT_WIDTH = 64;
    localparam int MUL_LATENCY   = 3;

endpackage
`default_nettype wire

// File: rtl/vedic_half_mul.sv
`default_nettype none
// ============================================================================
// Module   : vedic_half_mul
// Purpose  : Combinational HALF x HALF -> 2*HALF unsigned partial product.
// Revision : 1.0 - initial release
// ============================================================================
module vedic_half_mul #(
    parameter int HALF = 32
) (
    input  logic [HALF-1:0]   i_a,
    input  logic [HALF-1:0]   i_b,
    output logic [2*HALF-1:0] o_p
);

    assign o_p = {{HALF{1'b0}}, i_a} * {{HALF{1'b0}}, i_b};

endmodule
`default_nettype wire

// File: rtl/vedic_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : vedic_mul_pipe
// Purpose  : 3-stage valid/ready Vedic (Urdhva) multiplier, WIDTH x WIDTH.
//            Define SIGNED_MUL_EN to add the per-transaction sgn select.
// Revision : 1.0 - initial release
// ============================================================================
module vedic_mul_pipe
    import vedic_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef SIGNED_MUL_EN
    input  logic               sgn,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result
);

    localparam int HALF = WIDTH / 2;
    localparam int PW   = 2 * HALF;
    localparam int MW   = 2 * HALF + 2;

    logic               w_adv;
    logic [HALF-1:0]    w_al, w_ah, w_bl, w_bh;
    logic [PW-1:0]      w_p0, w_p1, w_p2, w_p3;
    logic [WIDTH-1:0]   w_corr;
    logic [MW-1:0]      w_mid;
    logic [WIDTH-1:0]   w_hi;

    logic               r_v1, r_v2, r_out_valid;
    logic [PW-1:0]      r_p0, r_p1, r_p2, r_p3;
    logic [WIDTH-1:0]   r_corr1;
    logic [MW-1:0]      r_mid;
    logic [HALF-1:0]    r_p0_lo;
    logic [PW-1:0]      r_p3_s2;
    logic [WIDTH-1:0]   r_corr2;
    logic [2*WIDTH-1:0] r_result;

    assign w_adv     = !r_out_valid || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign result    = r_result;

    assign {w_ah, w_al} = a;
    assign {w_bh, w_bl} = b;

    vedic_half_mul #(.HALF(HALF)) u_p0 (.i_a(w_al), .i_b(w_bl), .o_p(w_p0));
    vedic_half_mul #(.HALF(HALF)) u_p1 (.i_a(w_al), .i_b(w_bh), .o_p(w_p1));
    vedic_half_mul #(.HALF(HALF)) u_p2 (.i_a(w_ah), .i_b(w_bl), .o_p(w_p2));
    vedic_half_mul #(.HALF(HALF)) u_p3 (.i_a(w_ah), .i_b(w_bh), .o_p(w_p3));

    // Two's-complement fix-up: the upper half of the unsigned product must
    // lose b for a negative a and a for a negative b (mod 2^WIDTH).
`ifdef SIGNED_MUL_EN
    assign w_corr = sgn ? ((a[WIDTH-1] ? b : '0) + (b[WIDTH-1] ? a : '0)) : '0;
`else
    assign w_corr = '0;
`endif

    assign w_mid = {2'b00, r_p1} + {2'b00, r_p2} + {{(HALF+2){1'b0}}, r_p0[PW-1:HALF]};
    assign w_hi  = r_p3_s2 + {{(HALF-2){1'b0}}, r_mid[MW-1:HALF]} - r_corr2;

    // Datapath registers carry no reset; their contents only matter when
    // the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_p0    <= w_p0;
            r_p1    <= w_p1;
            r_p2    <= w_p2;
            r_p3    <= w_p3;
            r_corr1 <= w_corr;
            r_mid   <= w_mid;
            r_p0_lo <= r_p0[HALF-1:0];
            r_p3_s2 <= r_p3;
            r_corr2 <= r_corr1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else if (w_adv) begin
            r_v1        <= in_valid;
            r_v2        <= r_v1;
            r_out_valid <= r_v2;
            r_result    <= {w_hi, r_mid[HALF-1:0], r_p0_lo};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vedic_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_vedic_mul_pipe
// Purpose  : Directed + randomised self-checking bench for vedic_mul_pipe
//            (WIDTH = 64); signed cases active when SIGNED_MUL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vedic_mul_pipe;

    localparam int W = 64;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           sgn = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2*W-1:0] exp_q[$];

    vedic_mul_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SIGNED_MUL_EN
        .sgn       (sgn),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference product straight from integer arithmetic.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [2*W-1:0] xe, ye;
        xe = (s && x[W-1]) ? {{W{1'b1}}, x} : {{W{1'b0}}, x};
        ye = (s && y[W-1]) ? {{W{1'b1}}, y} : {{W{1'b0}}, y};
        return xe * ye;
    endfunction

    function automatic logic use_sgn(input logic s);
`ifdef SIGNED_MUL_EN
        return s;
`else
        return 1'b0 & s;
`endif
    endfunction

    // Scoreboard: one compare per meaningful output cycle, sampled on negedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            check("reset_out_valid", {127'd0, out_valid}, '0);
            check("reset_in_ready", {127'd0, in_ready}, 128'd1);
        end else begin
            check("in_ready_rule", {127'd0, in_ready}, {127'd0, (!out_valid || out_ready)});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", result, 128'hx);
                end else begin
                    check("scoreboard", result, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, use_sgn(sgn)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        in_valid = 1'b1;
        a = x;
        b = y;
        sgn = s;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        step();
        check("rst_out_valid", {127'd0, out_valid}, '0);
        check("rst_result", result, '0);
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();

        // All-ones squared, exact 3-cycle latency
        drive({W{1'b1}}, {W{1'b1}}, 1'b0);
        step();
        in_valid = 1'b0;
        check("lat_c1", {127'd0, out_valid}, '0);
        step();
        check("lat_c2", {127'd0, out_valid}, '0);
        step();
        check("lat_c3", {127'd0, out_valid}, 128'd1);
        check("ones_sq", result, 128'hFFFFFFFFFFFFFFFE_0000000000000001);
        step();

        // Back-to-back
        drive(64'd3, 64'd5, 1'b0);               step();
        drive(64'd7, 64'd11, 1'b0);              step();
        drive(64'h1_0000_0000, 64'h1_0000_0000, 1'b0); step();
        in_valid = 1'b0;
        check("b2b_0", result, 128'd15);
        step();
        check("b2b_1", result, 128'd77);
        check("b2b_1v", {127'd0, out_valid}, 128'd1);
        step();
        check("b2b_2", result, 128'h1_0000_0000_0000_0000);
        step();
        check("b2b_done", {127'd0, out_valid}, '0);

        // Stall with three in flight
        drive(64'd10, 64'd20, 1'b0);             step();
        drive(64'd100, 64'd3, 1'b0);             step();
        drive(64'h8000_0000_0000_0000, 64'd2, 1'b0); step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_in_ready", {127'd0, in_ready}, '0);
            check("stall_hold", result, 128'd200);
        end
        out_ready = 1'b1;
        step();
        check("drain_1", result, 128'd300);
        step();
        check("drain_2", result, 128'h1_0000_0000_0000_0000);
        step();
        check("drain_empty", {127'd0, out_valid}, '0);

        // Reset with two in flight
        drive(64'd5, 64'd6, 1'b0);               step();
        drive(64'd9, 64'd9, 1'b0);               step();
        in_valid = 1'b0;
        step();
        check("pre_rst_valid", {127'd0, out_valid}, 128'd1);
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {127'd0, out_valid}, '0);
        check("async_rst_result", result, '0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(64'd4, 64'd4, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        check("post_rst_c2", {127'd0, out_valid}, '0);
        step();
        check("post_rst_res", result, 128'd16);
        step();
        check("post_rst_empty", {127'd0, out_valid}, '0);

`ifdef SIGNED_MUL_EN
        drive(-64'sd3, 64'd7, 1'b1);             step();
        drive(-64'sd3, 64'd7, 1'b0);             step();
        in_valid = 1'b0;
        step();
        check("signed_neg", result, {128{1'b1}} - 128'd20);
        step();
        check("unsigned_same", result, 128'h6_FFFF_FFFF_FFFF_FFEB);
        step();
`endif

        // Random traffic with random back-pressure
        for (int i = 0; i < 3000; i++) begin
            int pick;
            logic [W-1:0] x, y;
            pick = $urandom_range(0, 7);
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            if (pick == 0) x = '1;
            if (pick == 1) y = '0;
            if (pick == 2) begin x = '1; y = '1; end
            in_valid  = ($urandom_range(0, 3) != 0);
            a = x;
            b = y;
            sgn = $urandom_range(0, 1) != 0;
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        step();
        check("final_queue_empty", 128'(exp_q.size()), '0);
        check("final_out_valid", {127'd0, out_valid}, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
